// File: rtl/cic_interp_sched.sv
// Rate scheduler for the CIC interpolator feeding the delta-sigma modulator.
// Buffers one input-rate sample and follows the modulator's request strobe.
// Each request produces one integrator step. Every R-th request, on phase 0,
// the buffered sample is forwarded to the comb stage. The remaining phases
// are zero-stuffed. An empty buffer on a sample phase sets a sticky underrun.
module cic_interp_sched #(
  parameter int WIDTH  = 16,
  parameter int RATE_W = 8
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic              cfg_en,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              cfg_clr,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              mod_req,
  output logic [WIDTH-1:0]  comb_tdata,
  output logic              comb_tvalid,
  output logic              integ_en,
  output logic              stuff_zero,
  output logic [RATE_W-1:0] phase,
  output logic              underrun,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

  state_t            state_q;
  logic [RATE_W-1:0] r_q;
  logic [RATE_W-1:0] phase_q;
  logic [WIDTH-1:0]  buf_q;
  logic [WIDTH-1:0]  buf_d;
  logic              buf_full_q;
  logic              buf_full_d;
  logic              underrun_q;
  logic              underrun_d;
  logic [WIDTH-1:0]  comb_tdata_q;
  logic              comb_tvalid_q;
  logic              integ_en_q;
  logic              stuff_zero_q;

  logic [RATE_W-1:0] rate_eff;
  logic              sample_phase;
  logic              consume;
  logic              load;
  logic              phase_last;

  // A ratio of zero would never wrap, so it is treated as one.
  assign rate_eff     = (cfg_rate == '0) ? RATE_ONE : cfg_rate;
  assign sample_phase = cfg_en & (state_q == RUN) & mod_req & (phase_q == '0);
  assign consume      = sample_phase & buf_full_q;
  assign phase_last   = (phase_q == (r_q - RATE_ONE));

  // Ready depends only on state and the request, never on tvalid.
  assign s_axis_tready = cfg_en & (~buf_full_q | consume);
  assign load          = s_axis_tvalid & s_axis_tready;

  // Next state of the holding register: flush on disable; a load wins over a consume.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (!cfg_en) begin
      buf_full_d = 1'b0;
    end else begin
      if (consume) begin
        buf_full_d = 1'b0;
      end
      if (load) begin
        buf_full_d = 1'b1;
        buf_d      = s_axis_tdata;
      end
    end
  end

  // Sticky underrun: a new event takes priority over a clear in the same cycle.
  always_comb begin
    underrun_d = underrun_q;
    if (cfg_clr) begin
      underrun_d = 1'b0;
    end
    if (sample_phase && !buf_full_q) begin
      underrun_d = 1'b1;
    end
  end

  // Holding register and underrun flag.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
    end
  end

  // Run FSM: phase counter, ratio latch and registered strobes to comb and integrator.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      r_q           <= RATE_ONE;
      phase_q       <= '0;
      comb_tdata_q  <= '0;
      comb_tvalid_q <= 1'b0;
      integ_en_q    <= 1'b0;
      stuff_zero_q  <= 1'b0;
    end else begin
      comb_tvalid_q <= 1'b0;
      integ_en_q    <= 1'b0;
      stuff_zero_q  <= 1'b0;
      if (!cfg_en) begin
        state_q <= IDLE;
        phase_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= PRIME;
            r_q     <= rate_eff;
            phase_q <= '0;
          end
          PRIME: begin
            if (buf_full_q) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            if (mod_req) begin
              integ_en_q <= 1'b1;
              if (phase_q == '0) begin
                comb_tvalid_q <= 1'b1;
                comb_tdata_q  <= buf_full_q ? buf_q : '0;
              end else begin
                stuff_zero_q <= 1'b1;
              end
              if (phase_last) begin
                phase_q <= '0;
                r_q     <= rate_eff;
              end else begin
                phase_q <= phase_q + RATE_ONE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign comb_tdata  = comb_tdata_q;
  assign comb_tvalid = comb_tvalid_q;
  assign integ_en    = integ_en_q;
  assign stuff_zero  = stuff_zero_q;
  assign phase       = phase_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cic_interp_sched.sv
// Self-checking bench for cic_interp_sched.
// A frame-level model predicts every output from the scheduler's rules.
// A negedge compare process checks the DUT against that model on every cycle.
// Directed scenarios add hand-computed literal checks that pin the model.
module tb_cic_interp_sched;

  localparam int WIDTH  = 16;
  localparam int RATE_W = 8;

  logic              aclk = 1'b0;
  logic              arst_n;
  logic              cfg_en;
  logic [RATE_W-1:0] cfg_rate;
  logic              cfg_clr;
  logic [WIDTH-1:0]  s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              mod_req;
  logic [WIDTH-1:0]  comb_tdata;
  logic              comb_tvalid;
  logic              integ_en;
  logic              stuff_zero;
  logic [RATE_W-1:0] phase;
  logic              underrun;
  logic              busy;

  int nVectors = 0;
  int nMiss    = 0;

  // Model state: mode 0 = idle, 1 = priming, 2 = running.
  int mMode;
  bit mFull;
  int mData;
  int mRate;
  int mPh;
  bit mUnd;
  bit eValid;
  bit eInteg;
  bit eStuff;
  int eData;
  bit modelLive = 1'b0;

  int combSeen[$];
  int stuffCount;

  cic_interp_sched #(
    .WIDTH (WIDTH),
    .RATE_W(RATE_W)
  ) dut (
    .aclk         (aclk),
    .arst_n       (arst_n),
    .cfg_en       (cfg_en),
    .cfg_rate     (cfg_rate),
    .cfg_clr      (cfg_clr),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .mod_req      (mod_req),
    .comb_tdata   (comb_tdata),
    .comb_tvalid  (comb_tvalid),
    .integ_en     (integ_en),
    .stuff_zero   (stuff_zero),
    .phase        (phase),
    .underrun     (underrun),
    .busy         (busy)
  );

  // Free-running clock with a 10-unit period.
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int effRate(input logic [RATE_W-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  // A sample is taken when enabled and the buffer is empty, or is being drained right now.
  function automatic bit modelReady();
    bit drain;
    drain = (mMode == 2) && (mod_req === 1'b1) && (mPh == 0) && mFull;
    return (cfg_en === 1'b1) && (!mFull || drain);
  endfunction

  // Model update, applying the scheduler rules once per clock to the inputs held stable across the edge.
  always @(posedge aclk) begin : model
    bit cons;
    bit ld;
    bit setU;
    if (arst_n === 1'b0) begin
      mMode = 0; mFull = 1'b0; mData = 0; mRate = 1; mPh = 0; mUnd = 1'b0;
      eValid = 1'b0; eInteg = 1'b0; eStuff = 1'b0; eData = 0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      cons   = (cfg_en === 1'b1) && (mMode == 2) && (mod_req === 1'b1) && (mPh == 0) && mFull;
      ld     = (s_axis_tvalid === 1'b1) && modelReady();
      setU   = 1'b0;
      eValid = 1'b0;
      eInteg = 1'b0;
      eStuff = 1'b0;
      if (cfg_en !== 1'b1) begin
        mMode = 0;
        mPh   = 0;
        mFull = 1'b0;
      end else begin
        if (mMode == 0) begin
          mMode = 1;
          mRate = effRate(cfg_rate);
          mPh   = 0;
        end else if (mMode == 1) begin
          if (mFull) mMode = 2;
        end else if (mod_req === 1'b1) begin
          eInteg = 1'b1;
          if (mPh == 0) begin
            eValid = 1'b1;
            eData  = mFull ? mData : 0;
            setU   = !mFull;
          end else begin
            eStuff = 1'b1;
          end
          mPh = (mPh + 1) % mRate;
          if (mPh == 0) mRate = effRate(cfg_rate);
        end
        if (cons) mFull = 1'b0;
        if (ld) begin
          mFull = 1'b1;
          mData = int'(s_axis_tdata);
        end
      end
      if (setU) mUnd = 1'b1;
      else if (cfg_clr === 1'b1) mUnd = 1'b0;
    end
  end

  // Compare process: every output against the model away from the active edge; also logs forwarded samples.
  always @(negedge aclk) begin
    if (modelLive) begin
      checkOutput("tready", 32'(s_axis_tready), 32'(modelReady()));
      checkOutput("comb_tvalid", 32'(comb_tvalid), 32'(eValid));
      checkOutput("integ_en", 32'(integ_en), 32'(eInteg));
      if (eInteg) checkOutput("stuff_zero", 32'(stuff_zero), 32'(eStuff));
      if (eValid) checkOutput("comb_tdata", 32'(comb_tdata), 32'(eData[WIDTH-1:0]));
      checkOutput("phase", 32'(phase), 32'(mPh));
      checkOutput("underrun", 32'(underrun), 32'(mUnd));
      checkOutput("busy", 32'(busy), 32'(mMode != 0));
      if (comb_tvalid === 1'b1) combSeen.push_back(int'(comb_tdata));
      if (integ_en === 1'b1 && stuff_zero === 1'b1) stuffCount++;
    end
  end

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input bit en, input int rate, input bit clr,
                               input bit tv, input int data, input bit req);
    cfg_en        = en;
    cfg_rate      = rate[RATE_W-1:0];
    cfg_clr       = clr;
    s_axis_tvalid = tv;
    s_axis_tdata  = data[WIDTH-1:0];
    mod_req       = req;
    @(posedge aclk);
    #1;
  endtask

  // Directed scenarios with literal expectations.
  initial begin
    arst_n = 1'b0;
    applyStimulus(0, 4, 0, 0, 0, 0);
    applyStimulus(0, 4, 0, 0, 0, 0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_phase", 32'(phase), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    checkOutput("reset_comb_tvalid", 32'(comb_tvalid), 32'd0);
    arst_n = 1'b1;

    // R=4: 100 loaded, 200 accepted on the first sample phase, 8 requests.
    combSeen.delete();
    stuffCount = 0;
    applyStimulus(1, 4, 0, 1, 100, 0);
    applyStimulus(1, 4, 0, 1, 200, 0);
    checkOutput("prime_to_run_busy", 32'(busy), 32'd1);
    applyStimulus(1, 4, 0, 1, 200, 1);
    checkOutput("req0_data", 32'(comb_tdata), 32'd100);
    for (int i = 1; i < 8; i++) applyStimulus(1, 4, 0, 0, 0, 1);
    applyStimulus(1, 4, 0, 0, 0, 0);
    checkOutput("r4_comb_count", 32'(combSeen.size()), 32'd2);
    if (combSeen.size() == 2) begin
      checkOutput("r4_first_sample", 32'(combSeen[0]), 32'd100);
      checkOutput("r4_second_sample", 32'(combSeen[1]), 32'd200);
    end
    checkOutput("r4_stuff_count", 32'(stuffCount), 32'd6);
    checkOutput("r4_phase_after_frame", 32'(phase), 32'd0);

    // Sample phase with nothing buffered: zero forwarded, underrun sticks until cleared.
    applyStimulus(1, 4, 0, 0, 0, 1);
    checkOutput("underrun_tvalid", 32'(comb_tvalid), 32'd1);
    checkOutput("underrun_tdata", 32'(comb_tdata), 32'd0);
    checkOutput("underrun_set", 32'(underrun), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4, 0, 0, 0, 0);
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);
    applyStimulus(1, 4, 1, 0, 0, 0);
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);

    // Ratio written 4->2 at phase 1: phases 2,3 still run, then frames of 2.
    applyStimulus(1, 2, 0, 1, 300, 1);
    applyStimulus(1, 2, 0, 0, 0, 1);
    applyStimulus(1, 2, 0, 0, 0, 1);
    checkOutput("ratechg_wrap_phase", 32'(phase), 32'd0);
    applyStimulus(1, 2, 0, 0, 0, 1);
    checkOutput("ratechg_sample", 32'(comb_tdata), 32'd300);
    checkOutput("ratechg_phase1", 32'(phase), 32'd1);
    applyStimulus(1, 2, 0, 0, 0, 1);
    checkOutput("ratechg_r2_wrap", 32'(phase), 32'd0);

    // Disable at phase 2 with a full buffer, then re-enable into PRIME.
    applyStimulus(0, 4, 0, 0, 0, 0);
    checkOutput("disable_idle", 32'(busy), 32'd0);
    applyStimulus(1, 4, 0, 1, 500, 0);
    applyStimulus(1, 4, 0, 1, 600, 0);
    applyStimulus(1, 4, 0, 1, 600, 1);
    applyStimulus(1, 4, 0, 0, 0, 1);
    checkOutput("pre_disable_phase", 32'(phase), 32'd2);
    applyStimulus(0, 4, 0, 1, 700, 1);
    checkOutput("drop_busy", 32'(busy), 32'd0);
    checkOutput("drop_phase", 32'(phase), 32'd0);
    checkOutput("drop_integ", 32'(integ_en), 32'd0);
    checkOutput("drop_tready", 32'(s_axis_tready), 32'd0);
    applyStimulus(1, 4, 0, 0, 0, 0);
    checkOutput("reenable_busy", 32'(busy), 32'd1);
    applyStimulus(1, 4, 0, 0, 0, 1);
    checkOutput("prime_ignores_req", 32'(integ_en), 32'd0);
    checkOutput("prime_flushed_ready", 32'(s_axis_tready), 32'd1);

    // Reset mid-run, then restart with ratio 0 behaving as R=1 under back-to-back traffic.
    applyStimulus(1, 4, 0, 1, 800, 0);
    applyStimulus(1, 4, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 0, 1);
    applyStimulus(1, 4, 0, 0, 0, 1);
    arst_n = 1'b0;
    applyStimulus(1, 4, 0, 0, 0, 1);
    arst_n = 1'b1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_phase", 32'(phase), 32'd0);
    checkOutput("midrst_integ", 32'(integ_en), 32'd0);
    checkOutput("midrst_tdata", 32'(comb_tdata), 32'd0);
    applyStimulus(1, 0, 0, 1, 1000, 0);
    applyStimulus(1, 0, 0, 1, 1001, 0);
    combSeen.delete();
    stuffCount = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 0, 1, 1001 + k, 1);
      checkOutput("r1_integ_latency", 32'(integ_en), 32'd1);
      checkOutput("r1_no_stuff", 32'(stuff_zero), 32'd0);
      checkOutput("r1_data", 32'(comb_tdata), 32'(1000 + k));
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("r1_forward_count", 32'(combSeen.size()), 32'd6);
    checkOutput("r1_stuff_count", 32'(stuffCount), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
